// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice allocator.
// Takes key press/release events over a valid/ready handshake and assigns
// each note to one of NUM_VOICES voices. Each voice has a gate, a held
// note code and a one-cycle retrigger pulse. Voices are tracked in
// least-recently-assigned order so that the oldest one can be reused.
// Optional build macro: VOICE_ALLOC_STEAL_EN. When it is defined, a press
// that finds every voice gated steals the oldest voice. When it is not
// defined, that press is dropped and steal_o stays 0.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_WIDTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             key_valid_i,
  output logic                             key_ready_o,
  input  logic                             key_on_i,
  input  logic [NOTE_WIDTH-1:0]            key_note_i,
  output logic [NUM_VOICES-1:0]            voice_gate_o,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note_o,
  output logic [NUM_VOICES-1:0]            voice_trig_o,
  output logic                             steal_o,
  output logic                             drop_o
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int RW = IW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ACT_RETRIG  = 3'd0,
    ACT_ALLOC   = 3'd1,
    ACT_STEAL   = 3'd2,
    ACT_RELEASE = 3'd3,
    ACT_DROP    = 3'd4
  } act_t;

  state_t                  state_r;
  state_t                  state_nx_s;
  logic                    ready_r;
  logic                    accept_s;

  logic                    ev_on_r;
  logic [NOTE_WIDTH-1:0]   ev_note_r;

  logic [NUM_VOICES-1:0]   gate_r;
  logic [NOTE_WIDTH-1:0]   note_r [NUM_VOICES];
  logic [RW-1:0]           rank_r [NUM_VOICES];

  logic [IW-1:0]           tgt_r;
  act_t                    act_r;
  logic [IW-1:0]           tgt_s;
  act_t                    act_s;

  logic                    hit_found_s;
  logic [IW-1:0]           hit_idx_s;
  logic                    free_found_s;
  logic [IW-1:0]           free_idx_s;
  logic [IW-1:0]           old_idx_s;

  logic [NUM_VOICES-1:0]   trig_r;
  logic                    steal_r;
  logic                    drop_r;

  assign accept_s     = key_valid_i && ready_r;
  assign key_ready_o  = ready_r;
  assign voice_gate_o = gate_r;
  assign voice_trig_o = trig_r;
  assign steal_o      = steal_r;
  assign drop_o       = drop_r;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_note_pack
    assign voice_note_o[v*NOTE_WIDTH +: NOTE_WIDTH] = note_r[v];
  end

  // State register; ready is registered from the next state so it is high exactly in IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nx_s;
      ready_r <= (state_nx_s == ST_IDLE);
    end
  end

  // Next-state logic: IDLE waits for a handshake, SEARCH and COMMIT take one cycle each.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx_s = ST_SEARCH;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SEARCH: state_nx_s = ST_COMMIT;
      ST_COMMIT: state_nx_s = ST_IDLE;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // Voice scan: find matching gated voice, first free voice and the oldest voice, then pick the action.
  always_comb begin
    hit_found_s  = 1'b0;
    hit_idx_s    = '0;
    free_found_s = 1'b0;
    free_idx_s   = '0;
    old_idx_s    = '0;
    tgt_s        = '0;
    act_s        = ACT_DROP;
    // Scanning from the top down leaves the lowest matching index in place.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (gate_r[i] && (note_r[i] == ev_note_r)) begin
        hit_found_s = 1'b1;
        hit_idx_s   = IW'(i);
      end else begin
        hit_found_s = hit_found_s;
      end
      if (!gate_r[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = IW'(i);
      end else begin
        free_found_s = free_found_s;
      end
      if (rank_r[i] == RW'(NUM_VOICES - 1)) begin
        old_idx_s = IW'(i);
      end else begin
        old_idx_s = old_idx_s;
      end
    end
    if (ev_on_r) begin
      if (hit_found_s) begin
        act_s = ACT_RETRIG;
        tgt_s = hit_idx_s;
      end else if (free_found_s) begin
        act_s = ACT_ALLOC;
        tgt_s = free_idx_s;
      end else begin
`ifdef VOICE_ALLOC_STEAL_EN
        act_s = ACT_STEAL;
        tgt_s = old_idx_s;
`else
        act_s = ACT_DROP;
        tgt_s = '0;
`endif
      end
    end else begin
      if (hit_found_s) begin
        act_s = ACT_RELEASE;
        tgt_s = hit_idx_s;
      end else begin
        act_s = ACT_DROP;
        tgt_s = '0;
      end
    end
  end

  // Datapath: capture the event, latch the scan result, then commit voice state and pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ev_on_r   <= 1'b0;
      ev_note_r <= '0;
      tgt_r     <= '0;
      act_r     <= ACT_DROP;
      gate_r    <= '0;
      trig_r    <= '0;
      steal_r   <= 1'b0;
      drop_r    <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_r[i] <= '0;
        rank_r[i] <= RW'(i);
      end
    end else begin
      trig_r  <= '0;
      steal_r <= 1'b0;
      drop_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            ev_on_r   <= key_on_i;
            ev_note_r <= key_note_i;
          end
        end
        ST_SEARCH: begin
          tgt_r <= tgt_s;
          act_r <= act_s;
        end
        ST_COMMIT: begin
          case (act_r)
            ACT_RETRIG, ACT_ALLOC, ACT_STEAL: begin
              gate_r[tgt_r] <= 1'b1;
              note_r[tgt_r] <= ev_note_r;
              trig_r[tgt_r] <= 1'b1;
`ifdef VOICE_ALLOC_STEAL_EN
              steal_r <= (act_r == ACT_STEAL);
`else
              steal_r <= 1'b0;
`endif
              // Target becomes newest; everything newer than it ages by one.
              for (int i = 0; i < NUM_VOICES; i++) begin
                if (IW'(i) == tgt_r) begin
                  rank_r[i] <= '0;
                end else if (rank_r[i] < rank_r[tgt_r]) begin
                  rank_r[i] <= rank_r[i] + RW'(1);
                end else begin
                  rank_r[i] <= rank_r[i];
                end
              end
            end
            ACT_RELEASE: begin
              // Note is kept so the envelope release plays at the right pitch.
              gate_r[tgt_r] <= 1'b0;
            end
            ACT_DROP: begin
              drop_r <= 1'b1;
            end
            default: begin
              drop_r <= 1'b0;
            end
          endcase
        end
        default: begin
          drop_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice allocator between the keypad/note front end and a bank of `NUM_VOICES` oscillator + envelope_generator voice datapaths. It accepts serialized key press/release events over a valid/ready handshake and assigns each note to a voice. Per voice it drives a gate (envelope `valid_i`), a held note code (frequency_control `sw_i`) and a one-cycle retrigger pulse. When every voice is busy it steals the least-recently-assigned voice.

## Interface
- `NUM_VOICES`, default 4: number of voices; 2..8.
- `NOTE_WIDTH`, default 4: note code width, matching the 16-key keypad.
- `clk_i`  in  1: system clock (`clk_12` domain).
- `rst_i`  in  1: synchronous, active-high reset.
- `key_valid_i`  in  1: event valid.
- `key_ready_o`  out  1: allocator can accept an event.
- `key_on_i`  in  1: 1 = press, 0 = release.
- `key_note_i`  in  NOTE_WIDTH: note code of the event.
- `voice_gate_o`  out  NUM_VOICES: per-voice gate.
- `voice_note_o`  out  NUM_VOICES*NOTE_WIDTH: per-voice note; voice v occupies bits [v*NOTE_WIDTH +: NOTE_WIDTH].
- `voice_trig_o`  out  NUM_VOICES: one-cycle pulse when a voice is (re)started.
- `steal_o`  out  1: one-cycle pulse when a busy voice was reassigned.
- `drop_o`  out  1: one-cycle pulse when an event caused no voice change.

## Operation
- FSM states: IDLE, SEARCH, COMMIT.
  - IDLE: `key_ready_o`=1. On `key_valid_i & key_ready_o`, capture `key_on_i`/`key_note_i` and go to SEARCH.
  - SEARCH: scan all voices and register the target index and action, then go to COMMIT.
  - COMMIT: update voice state and pulse outputs, then return to IDLE.
- Press, in priority order:
  - A gated voice already holds the note: retrigger that voice (lowest index if several). Gate stays 1; trig pulses.
  - Otherwise, the lowest-index voice with gate=0: set gate=1, load the note, pulse trig.
  - Otherwise, steal the voice with rank NUM_VOICES-1 (the oldest). Load the note, keep gate=1, pulse trig and `steal_o`.
- Release:
  - The lowest-index gated voice holding the note gets gate=0. Its note is retained so the envelope release uses the correct pitch. No trig.
  - If no gated voice matches: no change; pulse `drop_o`.
- LRU ranks: each voice has a unique rank 0..NUM_VOICES-1, where 0 is the newest.
  - On any press that targets voice v with rank r: every voice with rank < r increments, and v takes rank 0.
  - Releases and drops do not change ranks.
  - Ranks always remain a permutation; there are no ties.
- Reset values: all gates 0, notes 0, trig/steal/drop 0, rank[i]=i, state IDLE, `key_ready_o`=1 from the first cycle after reset.

## Timing
- Handshake at edge E0. SEARCH occupies E0→E1 and COMMIT occupies E1→E2.
- `voice_gate_o`/`voice_note_o` change at E2. `voice_trig_o`, `steal_o` and `drop_o` are high for exactly the cycle E2→E3.
- `key_ready_o` is low during SEARCH and COMMIT, and high again after E2. Maximum throughput is one event per 3 cycles.
- A `key_valid_i` held while `key_ready_o`=0 is not consumed. The event must be held until accepted; it is accepted at the edge after E2.
- Voice outputs are registered only; no combinational path from `key_*` inputs to voice outputs.
- `rst_i` asserted in any state: at that edge, return to IDLE and discard any in-flight event. No trig/steal/drop pulse is emitted for it. Reset wins over a simultaneous handshake.

## Configuration
- `VOICE_ALLOC_STEAL_EN` defined: a press with all voices gated steals the oldest voice as above.
- Not defined: that press is discarded. Gates, notes and ranks are unchanged and `drop_o` pulses; `steal_o` is tied to 0.

## Test plan
- Reset, then press notes 3, 7, 9 (NUM_VOICES=4) → voices 0/1/2 gate=1 with notes 3/7/9. voice_trig_o pulses 0001, 0010, 0100, each one cycle, 2 cycles after the handshake. Voice 3 gate=0.
- Press 3, 7, 9, 12, then press 5 with the macro on → voice 0 (oldest) gets note 5, trig=0001, steal_o=1. A second press of 1 steals voice 1.
- Same sequence with the macro off → press 5 gives drop_o=1, all voice notes unchanged, no trig.
- Press 7, then release 7 → gate 0 at E2, note stays 7, no trig. Release 7 again → drop_o=1.
- Press 7 twice → only voice 0 is used and trig 0001 pulses twice. Voice 1 stays idle and voice 0 becomes rank 0.
- Hold key_valid_i high continuously → exactly one acceptance per 3 cycles. Assert rst_i during COMMIT → no pulse, all gates 0, ready=1 next cycle.
